// File: rtl/tc_pl_acp_wr_if.sv
// Signal bundle between the capture engine requester, the write-request
// receiver and the PS ACP write channels (AW/W/B).
`timescale 1ns/1ps
interface tc_pl_acp_wr_if;
  // Requester side
  logic        acp0_tx_en;
  logic        acp0_tx_rdy;
  logic [31:0] acp0_tx_awaddr;
  logic [2:0]  acp0_tx_awid;
  logic        acp0_tx_wdreq;
  logic [63:0] acp0_tx_wdata;
  // AXI3 write address channel
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awid;
  logic [3:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [3:0]  m_axi_awcache;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  // AXI3 write data channel
  logic [63:0] m_axi_wdata;
  logic [2:0]  m_axi_wid;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  // AXI3 write response channel
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  // Status
  logic        wr_done;
  logic [15:0] err_cnt;

  modport master (
    input  acp0_tx_en, acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output acp0_tx_rdy, acp0_tx_wdreq,
    output m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awcache, m_axi_awvalid,
    output m_axi_wdata, m_axi_wid, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_bready, wr_done, err_cnt
  );

  modport slave (
    output acp0_tx_en, acp0_tx_awaddr, acp0_tx_awid, acp0_tx_wdata,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  acp0_tx_rdy, acp0_tx_wdreq,
    input  m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awcache, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wid, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_bready, wr_done, err_cnt
  );
endinterface

// File: rtl/tc_pl_acp_wr.sv
// ACP write-request receiver: accepts one burst request, pulls BURST_LEN
// 64-bit beats from the requester into a local buffer, then replays them as
// a single AXI3 INCR write and counts non-OKAY responses.
`timescale 1ns/1ps
module tc_pl_acp_wr #(
  parameter int         BURST_LEN = 8,
  parameter logic [3:0] AWCACHE   = 4'b1111
) (
  input  logic           clk125,
  input  logic           rst_n,
  tc_pl_acp_wr_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, AW, WDATA, BRESP} state_t;

  localparam logic [4:0] LEN_C  = 5'(BURST_LEN);
  localparam logic [3:0] LAST_C = 4'(BURST_LEN - 1);

  state_t      state_q, state_d;

  // Beat bookkeeping
  logic [4:0]  req_cnt_q, req_cnt_d;   // wdreq pulses issued so far
  logic        cap_en_q;               // wdata valid this cycle
  logic [3:0]  cap_idx_q, cap_idx_d;   // next buffer slot to fill
  logic [3:0]  w_idx_q, w_idx_d;       // beat currently on W
  logic [63:0] beat_q [16];

  // Registered outputs
  logic        rdy_q, rdy_d;
  logic        wdreq_q, wdreq_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        wlast_q, wlast_d;
  logic        bready_q, bready_d;
  logic        done_q, done_d;
  logic [15:0] err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  id_q, id_d;
  logic [3:0]  awlen_q, awlen_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [1:0]  awburst_q, awburst_d;
  logic [3:0]  awcache_q, awcache_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;

  logic        accept, aw_hs, w_hs, b_hs;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = bus.acp0_tx_en & rdy_q;
  assign aw_hs  = awvalid_q & bus.m_axi_awready;
  assign w_hs   = wvalid_q & bus.m_axi_wready;
  assign b_hs   = bready_q & bus.m_axi_bvalid;

  // State register
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (cap_en_q && cap_idx_q == LAST_C) state_d = AW;
      AW:      if (aw_hs) state_d = WDATA;
      WDATA:   if (w_hs && w_idx_q == LAST_C) state_d = BRESP;
      BRESP:   if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and beat counters
  always_comb begin
    rdy_d     = rdy_q;
    wdreq_d   = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    addr_d    = addr_q;
    id_d      = id_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    awcache_d = awcache_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    req_cnt_d = req_cnt_q;
    cap_idx_d = cap_idx_q;
    w_idx_d   = w_idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdy_d     = 1'b0;
          wdreq_d   = 1'b1;
          req_cnt_d = 5'd1;
          cap_idx_d = 4'd0;
          addr_d    = bus.acp0_tx_awaddr;
          id_d      = bus.acp0_tx_awid;
          awlen_d   = LAST_C;
          awsize_d  = 3'd3;
          awburst_d = 2'b01;
          awcache_d = AWCACHE;
          wstrb_d   = 8'hFF;
        end
      end
      FETCH: begin
        if (req_cnt_q < LEN_C) begin
          wdreq_d   = 1'b1;
          req_cnt_d = req_cnt_q + 5'd1;
        end
        if (cap_en_q) cap_idx_d = cap_idx_q + 4'd1;
        if (cap_en_q && cap_idx_q == LAST_C) awvalid_d = 1'b1;
      end
      AW: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = beat_q[0];
          wlast_d   = (LAST_C == 4'd0);
          w_idx_d   = 4'd0;
        end
      end
      WDATA: begin
        if (w_hs) begin
          if (w_idx_q == LAST_C) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            w_idx_d = w_idx_q + 4'd1;
            wdata_d = beat_q[w_idx_q + 4'd1];
            wlast_d = ((w_idx_q + 4'd1) == LAST_C);
          end
        end
      end
      BRESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          rdy_d    = 1'b1;
          if (bus.m_axi_bresp != 2'b00) err_d = sat_inc(err_q);
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers; a reset drops any partial burst
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b1;
      wdreq_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 16'd0;
      addr_q    <= 32'd0;
      id_q      <= 3'd0;
      awlen_q   <= 4'd0;
      awsize_q  <= 3'd0;
      awburst_q <= 2'd0;
      awcache_q <= 4'd0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
      req_cnt_q <= 5'd0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= 4'd0;
      w_idx_q   <= 4'd0;
    end else begin
      rdy_q     <= rdy_d;
      wdreq_q   <= wdreq_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      awcache_q <= awcache_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      req_cnt_q <= req_cnt_d;
      cap_en_q  <= wdreq_q;
      cap_idx_q <= cap_idx_d;
      w_idx_q   <= w_idx_d;
    end
  end

  // Beat buffer: requester data arrives one cycle after its wdreq
  always_ff @(posedge clk125) begin
    if (cap_en_q) beat_q[cap_idx_q] <= bus.acp0_tx_wdata;
  end

  assign bus.acp0_tx_rdy   = rdy_q;
  assign bus.acp0_tx_wdreq = wdreq_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awid    = id_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = awsize_q;
  assign bus.m_axi_awburst = awburst_q;
  assign bus.m_axi_awcache = awcache_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wid     = id_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_wlast   = wlast_q;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.wr_done       = done_q;
  assign bus.err_cnt       = err_q;

endmodule

// File: tb/tb_tc_pl_acp_wr.sv
// Directed bench for tc_pl_acp_wr: an L=8 instance for the main scenarios
// and an L=1 instance for back-to-back requests.
`timescale 1ns/1ps
module tb_tc_pl_acp_wr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tc_pl_acp_wr_if bus0();
  tc_pl_acp_wr_if bus1();

  tc_pl_acp_wr #(.BURST_LEN(8)) dut0 (.clk125(clk), .rst_n(rst_n), .bus(bus0.master));
  tc_pl_acp_wr #(.BURST_LEN(1)) dut1 (.clk125(clk), .rst_n(rst_n), .bus(bus1.master));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [31:0] base, input int k);
    logic [31:0] w;
    w = base + 32'(k);
    return {w, w};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT0 slave-side drivers ----------------
  int         aw_stall = 0;
  bit         w_toggle = 1'b0;
  bit         tog = 1'b0;
  logic [1:0] b_resp = 2'b00;
  int         aw_seen = 0;

  always @(posedge clk) begin
    #1;
    if (!bus0.m_axi_awvalid) begin
      aw_seen = 0;
      bus0.m_axi_awready = (aw_stall == 0);
    end else begin
      bus0.m_axi_awready = (aw_seen >= aw_stall);
      aw_seen++;
    end
    tog = ~tog;
    bus0.m_axi_wready = w_toggle ? tog : 1'b1;
    bus0.m_axi_bvalid = 1'b1;
    bus0.m_axi_bresp  = b_resp;
  end

  // Requester: answer each wdreq with data in the following cycle
  logic [31:0] req_base = 32'd0;
  int          req_k = 0;
  always begin
    @(negedge clk);
    if (bus0.acp0_tx_wdreq) begin
      @(posedge clk);
      #1;
      bus0.acp0_tx_wdata = beat_val(req_base, req_k);
      req_k++;
    end
  end

  // ---------------- DUT0 monitor ----------------
  int          acc_n, wdreq_n, wdreq_first, wdreq_last;
  int          aw_n, aw_cyc, w_first, done_n, done_cyc;
  int          aw_stall_n, w_stall_n;
  logic [31:0] aw_addr;
  logic [2:0]  aw_id, aw_size;
  logic [3:0]  aw_len, aw_cache;
  logic [1:0]  aw_burst;
  logic [11:0] w_misc;
  logic [63:0] w_data[$];
  logic        w_last[$];
  bit          aw_stalled = 1'b0, w_stalled = 1'b0;
  logic [63:0] aw_snap, w_snap;
  logic [11:0] w_misc_snap;
  logic [63:0] aw_pl0;
  logic [11:0] w_misc0;
  assign aw_pl0  = {16'h0, bus0.m_axi_awaddr, bus0.m_axi_awid, bus0.m_axi_awlen,
                    bus0.m_axi_awsize, bus0.m_axi_awburst, bus0.m_axi_awcache};
  assign w_misc0 = {bus0.m_axi_wlast, bus0.m_axi_wid, bus0.m_axi_wstrb};

  task automatic clr_mon();
    acc_n = 0; wdreq_n = 0; wdreq_first = 0; wdreq_last = 0;
    aw_n = 0; aw_cyc = 0; w_first = 0; done_n = 0; done_cyc = 0;
    aw_stall_n = 0; w_stall_n = 0;
    w_data.delete(); w_last.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.acp0_tx_en && bus0.acp0_tx_rdy) acc_n++;
      if (bus0.acp0_tx_wdreq) begin
        if (wdreq_n == 0) wdreq_first = cyc;
        wdreq_n++;
        wdreq_last = cyc;
      end
      if (aw_stalled) chk("aw_stable", {63'(aw_pl0), bus0.m_axi_awvalid}, {63'(aw_snap), 1'b1});
      if (w_stalled) begin
        chk("w_stable_data", bus0.m_axi_wdata, w_snap);
        chk("w_stable_ctl", 64'({bus0.m_axi_wvalid, w_misc0}), 64'({1'b1, w_misc_snap}));
      end
      aw_stalled  = bus0.m_axi_awvalid && !bus0.m_axi_awready;
      w_stalled   = bus0.m_axi_wvalid && !bus0.m_axi_wready;
      aw_snap     = aw_pl0;
      w_snap      = bus0.m_axi_wdata;
      w_misc_snap = w_misc0;
      if (aw_stalled) aw_stall_n++;
      if (w_stalled) w_stall_n++;
      if (bus0.m_axi_awvalid && bus0.m_axi_awready) begin
        aw_n++; aw_cyc = cyc;
        aw_addr = bus0.m_axi_awaddr; aw_id = bus0.m_axi_awid; aw_len = bus0.m_axi_awlen;
        aw_size = bus0.m_axi_awsize; aw_burst = bus0.m_axi_awburst; aw_cache = bus0.m_axi_awcache;
      end
      if (bus0.m_axi_wvalid && bus0.m_axi_wready) begin
        if (w_data.size() == 0) w_first = cyc;
        w_data.push_back(bus0.m_axi_wdata);
        w_last.push_back(bus0.m_axi_wlast);
        w_misc = w_misc0;
      end
      if (bus0.wr_done) begin done_n++; done_cyc = cyc; end
    end else begin
      aw_stalled = 1'b0;
      w_stalled  = 1'b0;
    end
  end

  // ---------------- DUT1 (L=1) environment ----------------
  int          acc1[$];
  int          aw1_n, done1_n;
  logic [3:0]  aw1_len[$];
  logic [63:0] w1_data[$];
  logic        w1_last[$];

  initial begin
    bus1.acp0_tx_wdata = 64'hDEAD_BEEF_0123_4567;
    bus1.m_axi_awready = 1'b1;
    bus1.m_axi_wready  = 1'b1;
    bus1.m_axi_bvalid  = 1'b1;
    bus1.m_axi_bresp   = 2'b00;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.acp0_tx_en && bus1.acp0_tx_rdy) acc1.push_back(cyc);
      if (bus1.m_axi_awvalid && bus1.m_axi_awready) begin aw1_n++; aw1_len.push_back(bus1.m_axi_awlen); end
      if (bus1.m_axi_wvalid && bus1.m_axi_wready) begin
        w1_data.push_back(bus1.m_axi_wdata);
        w1_last.push_back(bus1.m_axi_wlast);
      end
      if (bus1.wr_done) done1_n++;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic req0(input logic [31:0] addr, input logic [2:0] id,
                      input logic [31:0] base, output int t0);
    int t = 0;
    req_base = base;
    req_k = 0;
    @(posedge clk); #2;
    while (!bus0.acp0_tx_rdy && t < 200) begin @(posedge clk); #2; t++; end
    if (!bus0.acp0_tx_rdy) chk("rdy_timeout", 64'(bus0.acp0_tx_rdy), 64'd1);
    bus0.acp0_tx_en = 1'b1;
    bus0.acp0_tx_awaddr = addr;
    bus0.acp0_tx_awid = id;
    t0 = cyc;
    @(posedge clk); #2;
    bus0.acp0_tx_en = 1'b0;
  endtask

  task automatic pulse_busy(input logic [31:0] addr, input logic [2:0] id);
    @(posedge clk); #2;
    bus0.acp0_tx_en = 1'b1;
    bus0.acp0_tx_awaddr = addr;
    bus0.acp0_tx_awid = id;
    @(posedge clk); #2;
    bus0.acp0_tx_en = 1'b0;
  endtask

  task automatic wait_done(input int n, input int max_cyc);
    int t = 0;
    while (done_n < n && t < max_cyc) begin @(negedge clk); #1; t++; end
    if (done_n < n) chk("done_timeout", 64'(done_n), 64'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},     64'(bus0.acp0_tx_rdy),   64'd1);
    chk({tag, "_wdreq"},   64'(bus0.acp0_tx_wdreq), 64'd0);
    chk({tag, "_awvalid"}, 64'(bus0.m_axi_awvalid), 64'd0);
    chk({tag, "_wvalid"},  64'(bus0.m_axi_wvalid),  64'd0);
    chk({tag, "_wlast"},   64'(bus0.m_axi_wlast),   64'd0);
    chk({tag, "_bready"},  64'(bus0.m_axi_bready),  64'd0);
    chk({tag, "_done"},    64'(bus0.wr_done),       64'd0);
    chk({tag, "_err"},     64'(bus0.err_cnt),       64'd0);
    chk({tag, "_awpl"},    aw_pl0,                  64'd0);
    chk({tag, "_wdata"},   bus0.m_axi_wdata,        64'd0);
    chk({tag, "_wmisc"},   64'(w_misc0),            64'd0);
  endtask

  task automatic chk_beats(input string tag, input logic [31:0] base);
    chk({tag, "_nbeats"}, 64'(w_data.size()), 64'd8);
    for (int k = 0; k < 8 && k < w_data.size(); k++) begin
      chk({tag, "_wdata"}, w_data[k], beat_val(base, k));
      chk({tag, "_wlast"}, 64'(w_last[k]), 64'(k == 7));
    end
  endtask

  // Global time limit
  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, t, n_before;
    bus0.acp0_tx_en = 1'b0;
    bus0.acp0_tx_awaddr = 32'd0;
    bus0.acp0_tx_awid = 3'd0;
    bus1.acp0_tx_en = 1'b0;
    bus1.acp0_tx_awaddr = 32'd0;
    bus1.acp0_tx_awid = 3'd0;
    aw1_n = 0; done1_n = 0;
    clr_mon();
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals("rst0");
    chk("rst0_rdy1", 64'(bus1.acp0_tx_rdy), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Basic burst
    clr_mon();
    req0(32'h1000_0040, 3'd3, 32'h0, t0);
    wait_done(1, 100);
    chk("basic_wdreq_first", 64'(wdreq_first - t0), 64'd1);
    chk("basic_wdreq_last",  64'(wdreq_last - t0),  64'd8);
    chk("basic_wdreq_n",     64'(wdreq_n),          64'd8);
    chk("basic_aw_n",        64'(aw_n),             64'd1);
    chk("basic_aw_cyc",      64'(aw_cyc - t0),      64'd10);
    chk("basic_awaddr",      64'(aw_addr),          64'h1000_0040);
    chk("basic_awid",        64'(aw_id),            64'd3);
    chk("basic_awlen",       64'(aw_len),           64'd7);
    chk("basic_awsize",      64'(aw_size),          64'd3);
    chk("basic_awburst",     64'(aw_burst),         64'd1);
    chk("basic_awcache",     64'(aw_cache),         64'hF);
    chk("basic_w_first",     64'(w_first - t0),     64'd11);
    chk("basic_wid_wstrb",   64'(w_misc[10:0]),     64'({3'd3, 8'hFF}));
    chk_beats("basic", 32'h0);
    chk("basic_done_cyc",    64'(done_cyc - t0),    64'd20);

    // Backpressure on AW and W
    aw_stall = 5;
    w_toggle = 1'b1;
    clr_mon();
    req0(32'h1000_1000, 3'd5, 32'h100, t0);
    wait_done(1, 200);
    chk("bp_aw_n",      64'(aw_n),         64'd1);
    chk("bp_aw_cyc",    64'(aw_cyc - t0),  64'd15);
    chk("bp_aw_stalls", 64'(aw_stall_n),   64'd5);
    chk("bp_w_stalled", 64'(w_stall_n > 0), 64'd1);
    chk("bp_awaddr",    64'(aw_addr),      64'h1000_1000);
    chk_beats("bp", 32'h100);
    aw_stall = 0;
    w_toggle = 1'b0;

    // Error responses: three SLVERR then OKAY
    clr_mon();
    for (int i = 0; i < 4; i++) begin
      b_resp = (i < 3) ? 2'b10 : 2'b00;
      req0(32'h1000_0800 + 32'(i * 64), 3'(i), 32'h200, t0);
      wait_done(i + 1, 100);
      chk("err_cnt_step", 64'(bus0.err_cnt), 64'((i < 3) ? i + 1 : 3));
    end
    chk("err_cnt_final", 64'(bus0.err_cnt), 64'd3);
    chk("err_done_n",    64'(done_n),       64'd4);
    b_resp = 2'b00;

    // Busy requests during FETCH and WDATA are ignored
    clr_mon();
    w_toggle = 1'b1;
    req0(32'h1000_2000, 3'd1, 32'h300, t0);
    t = 0;
    while (wdreq_n < 2 && t < 50) begin @(negedge clk); #1; t++; end
    if (wdreq_n < 2) chk("busy_fetch_timeout", 64'(wdreq_n), 64'd2);
    pulse_busy(32'h2000_0000, 3'd6);
    t = 0;
    while (w_data.size() < 1 && t < 50) begin @(negedge clk); #1; t++; end
    if (w_data.size() < 1) chk("busy_wdata_timeout", 64'(w_data.size()), 64'd1);
    pulse_busy(32'h3000_0000, 3'd7);
    wait_done(1, 200);
    chk("busy_acc_n",  64'(acc_n),   64'd1);
    chk("busy_aw_n",   64'(aw_n),    64'd1);
    chk("busy_awaddr", 64'(aw_addr), 64'h1000_2000);
    chk("busy_awid",   64'(aw_id),   64'd1);
    chk_beats("busy", 32'h300);
    w_toggle = 1'b0;
    req0(32'h1000_3000, 3'd2, 32'h380, t0);
    wait_done(2, 100);
    chk("busy2_acc_n",  64'(acc_n),   64'd2);
    chk("busy2_aw_n",   64'(aw_n),    64'd2);
    chk("busy2_awaddr", 64'(aw_addr), 64'h1000_3000);

    // Reset in the middle of WDATA
    clr_mon();
    req0(32'h1000_4000, 3'd4, 32'h400, t0);
    t = 0;
    while (w_data.size() < 4 && t < 50) begin @(negedge clk); #1; t++; end
    if (w_data.size() < 4) chk("rst_wdata_timeout", 64'(w_data.size()), 64'd4);
    chk("rst_pre_err", 64'(bus0.err_cnt), 64'd3);
    n_before = w_data.size();
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals("rstmid");
    @(negedge clk); #1;
    chk_reset_vals("rstmid2");
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_no_more_beats", 64'(w_data.size()), 64'(n_before));
    chk("rst_no_aw_valid",   64'(bus0.m_axi_awvalid), 64'd0);
    clr_mon();
    req0(32'h1000_5000, 3'd7, 32'h500, t0);
    wait_done(1, 100);
    chk("fresh_aw_n",     64'(aw_n),          64'd1);
    chk("fresh_awaddr",   64'(aw_addr),       64'h1000_5000);
    chk("fresh_awid",     64'(aw_id),         64'd7);
    chk_beats("fresh", 32'h500);
    chk("fresh_done_cyc", 64'(done_cyc - t0), 64'd20);
    chk("fresh_err",      64'(bus0.err_cnt),  64'd0);

    // Back-to-back on the L=1 instance
    t = 0;
    @(posedge clk); #2;
    while (!bus1.acp0_tx_rdy && t < 20) begin @(posedge clk); #2; t++; end
    bus1.acp0_tx_en = 1'b1;
    bus1.acp0_tx_awaddr = 32'h2000_0100;
    bus1.acp0_tx_awid = 3'd2;
    @(posedge clk); #2;
    bus1.acp0_tx_en = 1'b0;
    t = 0;
    while (!bus1.acp0_tx_rdy && t < 20) begin @(posedge clk); #2; t++; end
    if (!bus1.acp0_tx_rdy) chk("b2b_rdy_timeout", 64'(bus1.acp0_tx_rdy), 64'd1);
    bus1.acp0_tx_en = 1'b1;
    bus1.acp0_tx_awaddr = 32'h2000_0108;
    bus1.acp0_tx_awid = 3'd3;
    @(posedge clk); #2;
    bus1.acp0_tx_en = 1'b0;
    t = 0;
    while (done1_n < 2 && t < 30) begin @(negedge clk); #1; t++; end
    chk("b2b_acc_n", 64'(acc1.size()), 64'd2);
    if (acc1.size() == 2) chk("b2b_spacing", 64'(acc1[1] - acc1[0]), 64'd6);
    chk("b2b_aw_n",    64'(aw1_n),          64'd2);
    chk("b2b_beats",   64'(w1_data.size()), 64'd2);
    chk("b2b_done_n",  64'(done1_n),        64'd2);
    for (int i = 0; i < aw1_len.size(); i++) chk("b2b_awlen", 64'(aw1_len[i]), 64'd0);
    for (int i = 0; i < w1_data.size(); i++) begin
      chk("b2b_wlast", 64'(w1_last[i]), 64'd1);
      chk("b2b_wdata", w1_data[i], 64'hDEAD_BEEF_0123_4567);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tc_pl_acp_wr.md
# tc_pl_acp_wr

Receiving end of the capture engine's `acp0_tx_*` write-request interface. It accepts one burst request (address and ID), then pulls `BURST_LEN` 64-bit beats from the requester into a local buffer. It replays the burst as a single AXI3 INCR write on the ACP port and reports completion and error counts. It sits between the capture data path and the PS ACP slave, all in the `clk125` domain.

## Interface
Parameters:
- `BURST_LEN`, 8, beats per request, legal range 1..16.
- `AWCACHE`, 4'b1111, constant driven on `m_axi_awcache` (coherent write-back).

Ports:
- `clk125`, in, 1: sole clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `acp0_tx_en`, in, 1: request strobe; accepted only when `acp0_tx_rdy`=1.
- `acp0_tx_rdy`, out, 1: block idle and able to accept a request.
- `acp0_tx_awaddr`, in, 32: burst start byte address; 8-byte aligned.
- `acp0_tx_awid`, in, 3: transaction ID.
- `acp0_tx_wdreq`, out, 1: beat request to the requester, one pulse per beat.
- `acp0_tx_wdata`, in, 64: beat data; valid in the cycle after the matching `wdreq`.
- `m_axi_awaddr`/`awid`/`awlen`/`awsize`/`awburst`/`awcache`, out, 32/3/4/3/2/4: AW payload.
- `m_axi_awvalid`, out, 1 / `m_axi_awready`, in, 1: AW handshake.
- `m_axi_wdata`/`wid`/`wstrb`/`wlast`, out, 64/3/8/1: W payload.
- `m_axi_wvalid`, out, 1 / `m_axi_wready`, in, 1: W handshake.
- `m_axi_bresp`, in, 2 / `m_axi_bvalid`, in, 1 / `m_axi_bready`, out, 1: B channel.
- `wr_done`, out, 1: one-cycle pulse when the B response is taken.
- `err_cnt`, out, 16: saturating count of non-OKAY responses.

## Operation
- The FSM has five states: IDLE, FETCH, AW, WDATA, BRESP. All outputs are registered.
- **IDLE**
  - `acp0_tx_rdy`=1.
  - When `acp0_tx_en` and `acp0_tx_rdy` are both high, latch `awaddr` and `awid`, then go to FETCH.
  - `acp0_tx_en` while `acp0_tx_rdy`=0 is ignored; it is neither queued nor counted.
- **FETCH**
  - `acp0_tx_wdreq`=1 for exactly `BURST_LEN` consecutive cycles.
  - The beat counter captures `acp0_tx_wdata` one cycle after each `wdreq` into `buf[k]`, k=0..`BURST_LEN`-1.
  - After the last capture, go to AW.
- **AW**
  - Drive `m_axi_awvalid`=1 until `m_axi_awready` is sampled high, then go to WDATA.
  - AW payload: `awaddr`=latched address, `awid`=latched ID, `awlen`=`BURST_LEN`-1, `awsize`=3, `awburst`=2'b01 (INCR), `awcache`=`AWCACHE`.
- **WDATA**
  - Drive `m_axi_wvalid`=1 with `buf[k]`; k advances on each `wvalid`&`wready`.
  - `wid`=latched ID, `wstrb`=8'hFF, `wlast`=1 only on beat `BURST_LEN`-1.
  - After the last handshake, go to BRESP.
- **BRESP**
  - `m_axi_bready`=1.
  - On `bvalid`: pulse `wr_done`; if `bresp`≠2'b00, increment `err_cnt`, saturating at 16'hFFFF.
  - Return to IDLE.
- `bid` is not checked.
- AW is always complete before the first W beat; address and data are never overlapped.
- 4 KB-boundary and alignment compliance is the requester's responsibility. The address is passed through unmodified.
- Payload outputs hold their value while valid is high and the partner is stalled (AXI stability rule).

## Timing
- Reset values: `acp0_tx_rdy`=1, `acp0_tx_wdreq`=0, `m_axi_awvalid`=0, `m_axi_wvalid`=0, `m_axi_wlast`=0, `m_axi_bready`=0, `wr_done`=0, `err_cnt`=0. All payload buses are 0.
- Cycle numbering, with cycle 0 as the accept cycle:
  - `acp0_tx_rdy`=0 from cycle 1.
  - `wdreq` is high in cycles 1..L (L=`BURST_LEN`).
  - Data is sampled in cycles 2..L+1.
  - `awvalid` first rises in cycle L+2.
- With `awready`, `wready` and `bvalid` held high:
  - AW handshake at L+2.
  - W beats at L+3..2L+2.
  - B handshake at 2L+3.
  - `wr_done`=1 and `acp0_tx_rdy`=1 in cycle 2L+4.
  - A new request is accepted no earlier than 2L+4.
- Backpressure on any channel stretches only that state. The buffer content is frozen.
- Reset mid-operation returns the block to IDLE immediately:
  - All outputs take their reset values, including `err_cnt`=0.
  - The partial burst is discarded; no AXI signal remains asserted.
  - The interconnect must be reset together with this block.

## Test plan
- **Basic burst:** L=8; request at 0x1000_0040, ID 3; requester returns beats 0x0..0x7 in the upper and lower words; all AXI readies held 1.
  - `wdreq` is high in cycles 1-8.
  - AW carries addr 0x1000_0040, len 7, size 3, burst 1.
  - W beats carry 0..7 in order, with `wlast` on the 8th beat only.
  - `wr_done` pulses in cycle 20.
- **Backpressure:** `awready` is held 0 for 5 cycles; `wready` toggles 1/0.
  - `awvalid` and `wvalid` payloads stay stable while stalled.
  - All 8 beats are delivered exactly once, in order.
- **Error response:** `bresp`=2'b10 on three bursts, then OKAY.
  - `err_cnt`=3.
  - `wr_done` pulses 4 times.
- **Busy request:** pulse `acp0_tx_en` with a new address during FETCH and again during WDATA.
  - Both pulses are ignored; exactly one AW is issued.
  - The next request is accepted only when `acp0_tx_rdy`=1.
- **Reset mid-burst:** drop `rst_n` while in WDATA after beat 4.
  - All outputs are at reset values while `rst_n`=0.
  - After release, a fresh request completes normally.
- **Back-to-back, L=1:** two requests, the second issued in the first cycle `acp0_tx_rdy` returns to 1.
  - Each request produces a single beat with `wlast`=1 and `awlen`=0.
  - Accepts are spaced exactly 2L+4=6 cycles apart.
